// File: rtl/arb_req_source.sv
// Requester-side agent for a req/grant arbiter: per-client job queues, fixed-length
// transfers on grant, grant legality checking and per-client grant counters.
module arb_req_source #(
    parameter int unsigned NumReq  = 3,
    parameter int unsigned XferLen = 4,
    parameter int unsigned CntW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NumReq-1:0]        job_push,
    input  logic [NumReq-1:0]        grant_in,
    output logic [NumReq-1:0]        req_out,
    output logic [NumReq-1:0]        busy,
    output logic [NumReq*CntW-1:0]   pending_cnt,
    output logic [NumReq*CntW-1:0]   grant_cnt,
    output logic                     proto_err
);
    localparam int unsigned XW = (XferLen > 1) ? $clog2(XferLen) : 1;
    localparam logic [CntW-1:0] CntMax   = '1;
    localparam logic [XW-1:0]   XferLast = XW'(XferLen - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t                  state_q [NumReq];
    state_t                  state_d [NumReq];
    logic [XW-1:0]           xcnt_q  [NumReq];
    logic [XW-1:0]           xcnt_d  [NumReq];
    logic [NumReq*CntW-1:0]  pend_d;
    logic [NumReq*CntW-1:0]  gcnt_d;
    logic [NumReq-1:0]       accept;
    logic [NumReq-1:0]       illegal;
    logic                    multi_hot;
    logic [NumReq-1:0]       req_d;
    logic [NumReq-1:0]       busy_d;

    // State register
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumReq; i++) begin
            if (rst) begin
                state_q[i] <= IDLE;
                xcnt_q[i]  <= '0;
            end else begin
                state_q[i] <= state_d[i];
                xcnt_q[i]  <= xcnt_d[i];
            end
        end
    end

    // Next state, grant acceptance/legality and counter updates
    always_comb begin
        multi_hot = (grant_in & (grant_in - NumReq'(1))) != '0;
        pend_d    = pending_cnt;
        gcnt_d    = grant_cnt;
        accept    = '0;
        illegal   = '0;
        for (int i = 0; i < NumReq; i++) begin
            state_d[i] = state_q[i];
            xcnt_d[i]  = xcnt_q[i];
            accept[i]  = grant_in[i] && (state_q[i] == REQ) && !multi_hot;
            // The first XFER cycle tolerates a grant held over by a registered arbiter
            illegal[i] = grant_in[i] && ((state_q[i] == IDLE) ||
                         ((state_q[i] == XFER) && (xcnt_q[i] != '0)));

            if (job_push[i] && !accept[i]) begin
                if (pending_cnt[i*CntW +: CntW] != CntMax)
                    pend_d[i*CntW +: CntW] = pending_cnt[i*CntW +: CntW] + CntW'(1);
            end else if (accept[i] && !job_push[i]) begin
                pend_d[i*CntW +: CntW] = pending_cnt[i*CntW +: CntW] - CntW'(1);
            end
            if (accept[i])
                gcnt_d[i*CntW +: CntW] = grant_cnt[i*CntW +: CntW] + CntW'(1);

            case (state_q[i])
                IDLE: begin
                    if (pend_d[i*CntW +: CntW] != '0) state_d[i] = REQ;
                end
                REQ: begin
                    if (accept[i]) begin
                        state_d[i] = XFER;
                        xcnt_d[i]  = '0;
                    end
                end
                XFER: begin
                    if (xcnt_q[i] == XferLast) begin
                        state_d[i] = (pend_d[i*CntW +: CntW] != '0) ? REQ : IDLE;
                        xcnt_d[i]  = '0;
                    end else begin
                        xcnt_d[i] = xcnt_q[i] + XW'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    xcnt_d[i]  = '0;
                end
            endcase
        end
    end

    // Output decode from next state, registered below
    always_comb begin
        req_d  = '0;
        busy_d = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_d[i]  = (state_d[i] == REQ);
            busy_d[i] = (state_d[i] == XFER);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_out     <= '0;
            busy        <= '0;
            pending_cnt <= '0;
            grant_cnt   <= '0;
            proto_err   <= 1'b0;
        end else begin
            req_out     <= req_d;
            busy        <= busy_d;
            pending_cnt <= pend_d;
            grant_cnt   <= gcnt_d;
            proto_err   <= proto_err | multi_hot | (|illegal);
        end
    end

endmodule
